// File: rtl/m14k_ejt_tap_seq_if.sv
// EJTAG TAP sequencer pin/chain bundle: pins and dr_tdo flow in, TAP state and action pulses flow out.
// master = pin driver / DR chain side, slave = the sequencer itself.
interface m14k_ejt_tap_seq_if #(
  parameter int IR_WIDTH = 5
);
  logic                ej_tck;
  logic                ej_tms;
  logic                ej_tdi;
  logic                dr_tdo;
  logic [3:0]          tap_state;
  logic [IR_WIDTH-1:0] ir;
  logic                tdi_s;
  logic                capture_dr_p;
  logic                shift_dr_p;
  logic                update_dr_p;
  logic                tlr;
  logic                tdo;
  logic                tdo_en;

  modport master (
    output ej_tck, ej_tms, ej_tdi, dr_tdo,
    input  tap_state, ir, tdi_s, capture_dr_p, shift_dr_p, update_dr_p, tlr, tdo, tdo_en
  );

  modport slave (
    input  ej_tck, ej_tms, ej_tdi, dr_tdo,
    output tap_state, ir, tdi_s, capture_dr_p, shift_dr_p, update_dr_p, tlr, tdo, tdo_en
  );
endinterface

// File: rtl/m14k_ejt_tap_seq.sv
// EJTAG TAP controller + IR, oversampling TCK/TMS/TDI in the gclk domain.
// Optional M14K_EJT_TAP_GLITCH_FILTER_EN: TCK must be stable for 2 samples before it counts.
module m14k_ejt_tap_seq #(
  parameter int                  SYNC_STAGES = 2,
  parameter int                  IR_WIDTH    = 5,
  parameter logic [IR_WIDTH-1:0] IR_RESET    = IR_WIDTH'(5'h01)
) (
  input logic                  gclk,
  input logic                  greset,
  m14k_ejt_tap_seq_if.slave    tap_if
);
  typedef enum logic [3:0] {
    S_EX2_DR   = 4'h0, S_EX1_DR = 4'h1, S_SH_DR  = 4'h2, S_PAUSE_DR = 4'h3,
    S_SEL_IR   = 4'h4, S_UPD_DR = 4'h5, S_CAP_DR = 4'h6, S_SEL_DR   = 4'h7,
    S_EX2_IR   = 4'h8, S_EX1_IR = 4'h9, S_SH_IR  = 4'hA, S_PAUSE_IR = 4'hB,
    S_RTI      = 4'hC, S_UPD_IR = 4'hD, S_CAP_IR = 4'hE, S_TLR      = 4'hF
  } state_t;

  logic [SYNC_STAGES-1:0] r_tck_sync, r_tms_sync, r_tdi_sync;
  logic                   w_tck_s, w_tms_s, w_tdi_s;
  logic                   r_tck_prev;
  logic                   w_tck_rise, w_tck_fall;
  state_t                 r_state, w_state_next;
  logic [IR_WIDTH-1:0]    r_ir, r_ir_sr;
  logic                   r_tdo, r_tdo_en;
  logic                   w_capture_dr_p, w_shift_dr_p, w_update_dr_p, w_tlr;

  always_ff @(posedge gclk) begin
    if (greset) begin
      r_tck_sync <= '0;
      r_tms_sync <= '0;
      r_tdi_sync <= '0;
    end else begin
      r_tck_sync <= {r_tck_sync[SYNC_STAGES-2:0], tap_if.ej_tck};
      r_tms_sync <= {r_tms_sync[SYNC_STAGES-2:0], tap_if.ej_tms};
      r_tdi_sync <= {r_tdi_sync[SYNC_STAGES-2:0], tap_if.ej_tdi};
    end
  end

`ifdef M14K_EJT_TAP_GLITCH_FILTER_EN
  logic r_tck_filt, r_tms_dly, r_tdi_dly;

  // TMS/TDI get one extra flop so they stay aligned with the filtered TCK.
  always_ff @(posedge gclk) begin
    if (greset) begin
      r_tck_filt <= 1'b0;
      r_tms_dly  <= 1'b0;
      r_tdi_dly  <= 1'b0;
    end else begin
      if (r_tck_sync[SYNC_STAGES-1] == r_tck_sync[SYNC_STAGES-2])
        r_tck_filt <= r_tck_sync[SYNC_STAGES-1];
      r_tms_dly <= r_tms_sync[SYNC_STAGES-1];
      r_tdi_dly <= r_tdi_sync[SYNC_STAGES-1];
    end
  end

  assign w_tck_s = r_tck_filt;
  assign w_tms_s = r_tms_dly;
  assign w_tdi_s = r_tdi_dly;
`else
  assign w_tck_s = r_tck_sync[SYNC_STAGES-1];
  assign w_tms_s = r_tms_sync[SYNC_STAGES-1];
  assign w_tdi_s = r_tdi_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge gclk) begin
    if (greset) r_tck_prev <= 1'b0;
    else        r_tck_prev <= w_tck_s;
  end

  assign w_tck_rise = w_tck_s & ~r_tck_prev;
  assign w_tck_fall = ~w_tck_s & r_tck_prev;

  always_ff @(posedge gclk) begin
    if (greset)          r_state <= S_TLR;
    else if (w_tck_rise) r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_TLR:      w_state_next = w_tms_s ? S_TLR    : S_RTI;
      S_RTI:      w_state_next = w_tms_s ? S_SEL_DR : S_RTI;
      S_SEL_DR:   w_state_next = w_tms_s ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR:   w_state_next = w_tms_s ? S_EX1_DR : S_SH_DR;
      S_SH_DR:    w_state_next = w_tms_s ? S_EX1_DR : S_SH_DR;
      S_EX1_DR:   w_state_next = w_tms_s ? S_UPD_DR : S_PAUSE_DR;
      S_PAUSE_DR: w_state_next = w_tms_s ? S_EX2_DR : S_PAUSE_DR;
      S_EX2_DR:   w_state_next = w_tms_s ? S_UPD_DR : S_SH_DR;
      S_UPD_DR:   w_state_next = w_tms_s ? S_SEL_DR : S_RTI;
      S_SEL_IR:   w_state_next = w_tms_s ? S_TLR    : S_CAP_IR;
      S_CAP_IR:   w_state_next = w_tms_s ? S_EX1_IR : S_SH_IR;
      S_SH_IR:    w_state_next = w_tms_s ? S_EX1_IR : S_SH_IR;
      S_EX1_IR:   w_state_next = w_tms_s ? S_UPD_IR : S_PAUSE_IR;
      S_PAUSE_IR: w_state_next = w_tms_s ? S_EX2_IR : S_PAUSE_IR;
      S_EX2_IR:   w_state_next = w_tms_s ? S_UPD_IR : S_SH_IR;
      S_UPD_IR:   w_state_next = w_tms_s ? S_SEL_DR : S_RTI;
    endcase
  end

  // Action pulses decode the pre-edge state in the same cycle as the detected rise.
  always_comb begin
    w_capture_dr_p = w_tck_rise && (r_state == S_CAP_DR);
    w_shift_dr_p   = w_tck_rise && (r_state == S_SH_DR);
    w_update_dr_p  = w_tck_rise && (r_state == S_UPD_DR);
    w_tlr          = (r_state == S_TLR);
  end

  always_ff @(posedge gclk) begin
    if (greset) begin
      r_ir    <= IR_RESET;
      r_ir_sr <= '0;
    end else if (w_tck_rise) begin
      case (r_state)
        S_CAP_IR: r_ir_sr <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
        S_SH_IR:  r_ir_sr <= {w_tdi_s, r_ir_sr[IR_WIDTH-1:1]};
        S_UPD_IR: r_ir    <= r_ir_sr;
        default:  ;
      endcase
      // Entering or staying in TLR forces IDCODE; Update-IR never leads to TLR.
      if (w_state_next == S_TLR) r_ir <= IR_RESET;
    end
  end

  always_ff @(posedge gclk) begin
    if (greset) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else if (w_tck_fall) begin
      if (r_state == S_SH_IR) begin
        r_tdo    <= r_ir_sr[0];
        r_tdo_en <= 1'b1;
      end else if (r_state == S_SH_DR) begin
        r_tdo    <= tap_if.dr_tdo;
        r_tdo_en <= 1'b1;
      end else begin
        r_tdo_en <= 1'b0;
      end
    end
  end

  assign tap_if.tap_state    = r_state;
  assign tap_if.ir           = r_ir;
  assign tap_if.tdi_s        = w_tdi_s;
  assign tap_if.capture_dr_p = w_capture_dr_p;
  assign tap_if.shift_dr_p   = w_shift_dr_p;
  assign tap_if.update_dr_p  = w_update_dr_p;
  assign tap_if.tlr          = w_tlr;
  assign tap_if.tdo          = r_tdo;
  assign tap_if.tdo_en       = r_tdo_en;
endmodule

// File: tb/tb_m14k_ejt_tap_seq.sv
// Bench for m14k_ejt_tap_seq: table of TCK cycles with expected state/IR/TDO, plus a pulse scoreboard.
module tb_m14k_ejt_tap_seq;
  localparam int IRW = 5;
`ifdef M14K_EJT_TAP_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic gclk = 1'b0;
  logic greset;
  always #5 gclk = ~gclk;

  m14k_ejt_tap_seq_if #(.IR_WIDTH(IRW)) bus ();

  m14k_ejt_tap_seq #(
    .SYNC_STAGES(2),
    .IR_WIDTH   (IRW),
    .IR_RESET   (5'h01)
  ) dut (
    .gclk  (gclk),
    .greset(greset),
    .tap_if(bus)
  );

  typedef struct packed {
    logic       tms;
    logic       tdi;
    logic       drt;
    logic [3:0] st;
    logic [4:0] ir;
    logic       tdo;
    logic       en;
  } vec_t;

  typedef struct packed {
    logic [2:0] kind;
    logic       tdi;
  } pexp_t;

  vec_t  vecs[64];
  int    nv = 0;
  pexp_t sbq[$];
  int    errors = 0;
  int    checks = 0;
  int    n_cap = 0, n_sh = 0, n_upd = 0;
  logic [3:0] cur_st;
  logic [7:0] tpat, dpat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic tms, input logic tdi, input logic drt,
                              input logic [3:0] st, input logic [4:0] ir,
                              input logic tdo, input logic en);
    vecs[nv] = {tms, tdi, drt, st, ir, tdo, en};
    nv++;
  endfunction

  // One TCK period: inputs settle while low, rise, hold high, fall, hold low.
  task automatic tck_cycle(input logic tms, input logic tdi, input logic drt);
    @(negedge gclk);
    bus.ej_tms = tms;
    bus.ej_tdi = tdi;
    bus.dr_tdo = drt;
    repeat (3) @(negedge gclk);
    if (cur_st == 4'h6)      sbq.push_back({3'b100, tdi});
    else if (cur_st == 4'h2) sbq.push_back({3'b010, tdi});
    else if (cur_st == 4'h5) sbq.push_back({3'b001, tdi});
    bus.ej_tck = 1'b1;
    repeat (5) @(negedge gclk);
    bus.ej_tck = 1'b0;
    repeat (5) @(negedge gclk);
  endtask

  logic [2:0] mon_kind;
  pexp_t      mon_p;
  always @(negedge gclk) begin
    if (greset === 1'b0) begin
      mon_kind = {bus.capture_dr_p, bus.shift_dr_p, bus.update_dr_p};
      if (mon_kind != 3'b000) begin
        if (mon_kind[2]) n_cap++;
        if (mon_kind[1]) n_sh++;
        if (mon_kind[0]) n_upd++;
        if (sbq.size() == 0) begin
          chk("pulse_unexpected", 32'(mon_kind), 32'd0);
        end else begin
          mon_p = sbq.pop_front();
          chk("pulse_kind", 32'(mon_kind), 32'(mon_p.kind));
          chk("pulse_tdi", 32'(bus.tdi_s), 32'(mon_p.tdi));
          $display("pulse kind=%b tdi_s=%b state=%h", mon_kind, bus.tdi_s, bus.tap_state);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    greset     = 1'b1;
    bus.ej_tck = 1'b0;
    bus.ej_tms = 1'b0;
    bus.ej_tdi = 1'b0;
    bus.dr_tdo = 1'b0;
    cur_st     = 4'hF;
    tpat       = 8'hB4;
    dpat       = 8'h6D;

    // From RTI: five TMS=1 rises reach TLR.
    add(1, 0, 0, 4'h7, 5'h01, 0, 0);
    add(1, 0, 0, 4'h4, 5'h01, 0, 0);
    add(1, 0, 0, 4'hF, 5'h01, 0, 0);
    add(1, 0, 0, 4'hF, 5'h01, 0, 0);
    add(1, 0, 0, 4'hF, 5'h01, 0, 0);
    add(0, 0, 0, 4'hC, 5'h01, 0, 0);
    // IR scan of 5'h0A, LSB first; TDO shows the 00001 capture value.
    add(1, 0, 0, 4'h7, 5'h01, 0, 0);
    add(1, 0, 0, 4'h4, 5'h01, 0, 0);
    add(0, 0, 0, 4'hE, 5'h01, 0, 0);
    add(0, 0, 0, 4'hA, 5'h01, 1, 1);
    add(0, 0, 0, 4'hA, 5'h01, 0, 1);
    add(0, 1, 0, 4'hA, 5'h01, 0, 1);
    add(0, 0, 0, 4'hA, 5'h01, 0, 1);
    add(0, 1, 0, 4'hA, 5'h01, 0, 1);
    add(1, 0, 0, 4'h9, 5'h01, 0, 0);
    add(1, 0, 0, 4'hD, 5'h01, 0, 0);
    add(0, 0, 0, 4'hC, 5'h0A, 0, 0);
    // 8-bit DR scan.
    add(1, 0, 0, 4'h7, 5'h0A, 0, 0);
    add(0, 0, 0, 4'h6, 5'h0A, 0, 0);
    add(0, 0, dpat[0], 4'h2, 5'h0A, dpat[0], 1);
    for (int k = 0; k < 7; k++)
      add(0, tpat[k], dpat[k+1], 4'h2, 5'h0A, dpat[k+1], 1);
    add(1, tpat[7], 0, 4'h1, 5'h0A, dpat[7], 0);
    add(1, 0, 0, 4'h5, 5'h0A, dpat[7], 0);
    add(0, 0, 0, 4'hC, 5'h0A, dpat[7], 0);

    repeat (3) @(negedge gclk);
    chk("rst_state", 32'(bus.tap_state), 32'hF);
    chk("rst_ir", 32'(bus.ir), 32'h01);
    chk("rst_tdo", 32'(bus.tdo), 32'h0);
    chk("rst_tdo_en", 32'(bus.tdo_en), 32'h0);
    chk("rst_tlr", 32'(bus.tlr), 32'h1);
    chk("rst_pulses", 32'({bus.capture_dr_p, bus.shift_dr_p, bus.update_dr_p}), 32'h0);
    greset = 1'b0;
    repeat (3) @(negedge gclk);

    // Pin-to-state latency from TLR with TMS=0.
    bus.ej_tms = 1'b0;
    repeat (3) @(negedge gclk);
    bus.ej_tck = 1'b1;
    repeat (LAT - 1) @(negedge gclk);
    chk("lat_before", 32'(bus.tap_state), 32'hF);
    @(negedge gclk);
    chk("lat_at", 32'(bus.tap_state), 32'hC);
    $display("latency: state=%h after %0d gclk", bus.tap_state, LAT);
    bus.ej_tck = 1'b0;
    repeat (5) @(negedge gclk);
    cur_st = 4'hC;

    for (int i = 0; i < nv; i++) begin
      v = vecs[i];
      tck_cycle(v.tms, v.tdi, v.drt);
      cur_st = v.st;
      chk($sformatf("vec%0d_state", i), 32'(bus.tap_state), 32'(v.st));
      chk($sformatf("vec%0d_ir", i), 32'(bus.ir), 32'(v.ir));
      chk($sformatf("vec%0d_tdo", i), 32'(bus.tdo), 32'(v.tdo));
      chk($sformatf("vec%0d_tdo_en", i), 32'(bus.tdo_en), 32'(v.en));
      chk($sformatf("vec%0d_tlr", i), 32'(bus.tlr), 32'(v.st == 4'hF));
      $display("vec%0d tms=%b tdi=%b state=%h ir=%h tdo=%b en=%b", i, v.tms, v.tdi,
               bus.tap_state, bus.ir, bus.tdo, bus.tdo_en);
    end
    chk("dr_n_capture", 32'(n_cap), 32'd1);
    chk("dr_n_shift", 32'(n_sh), 32'd8);
    chk("dr_n_update", 32'(n_upd), 32'd1);
    chk("dr_queue_empty", 32'(sbq.size()), 32'd0);

    // A 3-gclk TCK glitch counts as one rise: RTI -> Select-DR.
    bus.ej_tms = 1'b1;
    repeat (3) @(negedge gclk);
    bus.ej_tck = 1'b1;
    repeat (3) @(negedge gclk);
    bus.ej_tck = 1'b0;
    repeat (6) @(negedge gclk);
    chk("glitch3_state", 32'(bus.tap_state), 32'h7);
    $display("glitch3: state=%h", bus.tap_state);
    cur_st = 4'h7;

`ifdef M14K_EJT_TAP_GLITCH_FILTER_EN
    bus.ej_tms = 1'b0;
    repeat (3) @(negedge gclk);
    bus.ej_tck = 1'b1;
    @(negedge gclk);
    bus.ej_tck = 1'b0;
    repeat (6) @(negedge gclk);
    chk("glitch1_state", 32'(bus.tap_state), 32'h7);
    $display("glitch1: state=%h", bus.tap_state);
`endif

    // Reset after 3 Shift-IR bits: IR must not load the partial scan.
    tck_cycle(1, 0, 0); cur_st = 4'h4;
    tck_cycle(0, 0, 0); cur_st = 4'hE;
    tck_cycle(0, 0, 0); cur_st = 4'hA;
    for (int k = 0; k < 3; k++) begin
      tck_cycle(0, 1, 0);
      cur_st = 4'hA;
    end
    chk("shir_state", 32'(bus.tap_state), 32'hA);
    chk("shir_tdo_en", 32'(bus.tdo_en), 32'h1);
    greset = 1'b1;
    @(negedge gclk);
    greset = 1'b0;
    chk("irrst_state", 32'(bus.tap_state), 32'hF);
    chk("irrst_ir", 32'(bus.ir), 32'h01);
    chk("irrst_tdo_en", 32'(bus.tdo_en), 32'h0);
    chk("irrst_tdo", 32'(bus.tdo), 32'h0);
    $display("reset in Shift-IR: state=%h ir=%h en=%b", bus.tap_state, bus.ir, bus.tdo_en);
    cur_st = 4'hF;

    // Reset while in Shift-DR with TDO driven high clears tdo.
    tck_cycle(0, 0, 0); cur_st = 4'hC;
    tck_cycle(1, 0, 0); cur_st = 4'h7;
    tck_cycle(0, 0, 0); cur_st = 4'h6;
    tck_cycle(0, 0, 1); cur_st = 4'h2;
    chk("shdr_tdo", 32'(bus.tdo), 32'h1);
    chk("shdr_tdo_en", 32'(bus.tdo_en), 32'h1);
    greset = 1'b1;
    @(negedge gclk);
    greset = 1'b0;
    chk("drrst_state", 32'(bus.tap_state), 32'hF);
    chk("drrst_tdo", 32'(bus.tdo), 32'h0);
    chk("drrst_tdo_en", 32'(bus.tdo_en), 32'h0);
    $display("reset in Shift-DR: state=%h tdo=%b en=%b", bus.tap_state, bus.tdo, bus.tdo_en);
    repeat (4) @(negedge gclk);
    chk("final_queue_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
